// File: rtl/detect_scheduler_pkg.sv
// Shared encodings for the detect scheduler: detector core states, controller
// states and default sizing.
package detect_scheduler_pkg;

  localparam int DEF_NREQ   = 4;
  localparam int DEF_WORD_W = 8;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } core_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/detect_scheduler_seq_fsm_core.sv
// Serial pattern-detector core: five-state FSM with synchronous clear and
// enable; next_state exposes the transition for the current input bit.
module seq_fsm_core
  import detect_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       in,
  output logic [2:0] state,
  output logic [2:0] next_state
);

  core_state_t state_q;
  core_state_t state_d;

  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = in ? S1 : S0;
      S1:      state_d = in ? S1 : S2;
      S2:      state_d = in ? S3 : S0;
      S3:      state_d = in ? S4 : S2;
      S4:      state_d = in ? S1 : S2;
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S0;
    end else if (clear) begin
      state_q <= S0;
    end else if (en) begin
      state_q <= state_d;
    end
  end

  assign state      = state_q;
  assign next_state = state_d;

endmodule

// File: rtl/detect_scheduler.sv
// Round-robin scheduler that time-shares one serial detector core between
// NREQ requesters, shifting each granted word MSB-first through the core.
module detect_scheduler
  import detect_scheduler_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int WORD_W = DEF_WORD_W,
  parameter int ID_W   = $clog2(NREQ),
  parameter int HIT_W  = $clog2(WORD_W + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WORD_W-1:0]   data,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     done,
  output logic [ID_W-1:0]          done_id,
  output logic [2:0]               result,
  output logic [HIT_W-1:0]         hits
);

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  ctrl_state_t       state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   win_q, win_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HIT_W-1:0]  hitcnt_q, hitcnt_d;
  logic [HIT_W-1:0]  hits_q, hits_d;
  logic [2:0]        result_q, result_d;
  logic [ID_W-1:0]   done_id_q, done_id_d;

  logic              any_req;
  logic [ID_W-1:0]   pick;
  logic [ID_W-1:0]   pick_next;
  logic              core_clear;
  logic              core_en;
  logic [2:0]        core_state;
  logic [2:0]        core_next;
  logic              hit;
  logic              unused_core_state;

  // Round-robin search starting at the pointer, wrapping at NREQ.
  always_comb begin
    int idx;
    any_req = 1'b0;
    pick    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        pick    = ID_W'(idx);
      end
    end
  end

  assign pick_next = (int'(pick) == NREQ - 1) ? '0 : pick + 1'b1;

  assign core_clear = (state_q == GRANT);
  assign core_en    = (state_q == SHIFT);
  assign hit        = (core_next == 3'(S4));

  seq_fsm_core u_core (
    .clk        (clk),
    .reset      (reset),
    .clear      (core_clear),
    .en         (core_en),
    .in         (shreg_q[WORD_W-1]),
    .state      (core_state),
    .next_state (core_next)
  );

  assign unused_core_state = ^core_state;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    hitcnt_d  = hitcnt_q;
    hits_d    = hits_q;
    result_d  = result_q;
    done_id_d = done_id_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          win_d   = pick;
          ptr_d   = pick_next;
        end
      end
      GRANT: begin
        shreg_d  = data[int'(win_q)*WORD_W +: WORD_W];
        cnt_d    = '0;
        hitcnt_d = '0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        shreg_d  = shreg_q << 1;
        cnt_d    = cnt_q + 1'b1;
        hitcnt_d = hitcnt_q + HIT_W'(hit);
        // Final step: publish the post-shift core state and hit total.
        if (cnt_q == CNT_W'(WORD_W - 1)) begin
          state_d   = DONE;
          result_d  = core_next;
          hits_d    = hitcnt_q + HIT_W'(hit);
          done_id_d = win_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      shreg_q   <= '0;
      cnt_q     <= '0;
      hitcnt_q  <= '0;
      hits_q    <= '0;
      result_q  <= '0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      hitcnt_q  <= hitcnt_d;
      hits_q    <= hits_d;
      result_q  <= result_d;
      done_id_q <= done_id_d;
    end
  end

  always_comb begin
    gnt = '0;
    if (state_q != IDLE) begin
      gnt[win_q] = 1'b1;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign done_id = done_id_q;
  assign result  = result_q;
  assign hits    = hits_q;

endmodule

// File: tb/tb_detect_scheduler.sv
// Scoreboard bench for detect_scheduler: directed jobs push expected results,
// a done monitor pops and compares them.
module tb_detect_scheduler;

  localparam int NREQ   = 4;
  localparam int WORD_W = 8;
  localparam int ID_W   = 2;
  localparam int HIT_W  = 4;

  logic                   clk;
  logic                   rst_n;
  logic [NREQ-1:0]        req;
  logic [NREQ*WORD_W-1:0] data;
  logic [NREQ-1:0]        gnt;
  logic                   busy;
  logic                   done;
  logic [ID_W-1:0]        done_id;
  logic [2:0]             result;
  logic [HIT_W-1:0]       hits;

  typedef struct {
    int id;
    int res;
    int hit;
  } exp_t;

  exp_t exp_q[$];
  int   done_cyc[$];
  exp_t mon_e;
  int   checks;
  int   errors;
  int   cyc;
  int   done_cnt;

  detect_scheduler #(
    .NREQ   (NREQ),
    .WORD_W (WORD_W),
    .ID_W   (ID_W),
    .HIT_W  (HIT_W)
  ) dut (
    .clk     (clk),
    .reset   (rst_n),
    .req     (req),
    .data    (data),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .result  (result),
    .hits    (hits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int id, input int res, input int hit);
    exp_t e;
    e.id  = id;
    e.res = res;
    e.hit = hit;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_id %0d, expected no done", done_id);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_id", 32'(done_id), 32'(mon_e.id));
        check("result", 32'(result), 32'(mon_e.res));
        check("hits", 32'(hits), 32'(mon_e.hit));
      end
    end
  end

  // Called at a negedge with the controller idle.
  task automatic run_job(input int id, input logic [WORD_W-1:0] word,
                         input int res, input int hit, input bit corrupt);
    int n;
    data[id*WORD_W +: WORD_W] = word;
    req = NREQ'(1) << id;
    push_exp(id, res, hit);
    @(negedge clk);
    check("job_gnt", 32'(gnt), 32'(1) << id);
    check("job_busy", 32'(busy), 32'd1);
    req = '0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (corrupt && n == 3) data[id*WORD_W +: WORD_W] = ~word;
    end
    check("done_latency", 32'(n), 32'(WORD_W + 1));
    @(negedge clk);
    check("idle_after_done", 32'(busy), 32'd0);
    check("gnt_after_done", 32'(gnt), 32'd0);
  endtask

  task automatic wait_grant(input int id);
    int n;
    n = 0;
    while (gnt != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    while (gnt == 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no grant, expected grant to requester %0d", id);
    end else begin
      check("grant_order", 32'(gnt), 32'(1) << id);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int snap;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    done_cnt = 0;
    rst_n    = 1'b0;
    req      = '0;
    data     = '0;

    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("quiet_busy", 32'(busy), 32'd0);
      check("quiet_outs", {gnt, done, 2'(done_id), result, hits}, 32'd0);
    end

    run_job(0, 8'b1011_0000, 0, 1, 1'b0);
    run_job(1, 8'b1011_1011, 4, 2, 1'b0);
    run_job(1, 8'hFF,        1, 0, 1'b0);
    run_job(2, 8'b1011_0110, 2, 2, 1'b1);

    // Abort a job with reset in the middle of SHIFT.
    snap = done_cnt;
    data[0 +: WORD_W] = 8'hFF;
    req = 4'b0001;
    @(negedge clk);
    check("abort_gnt", 32'(gnt), 32'd1);
    req = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_gnt_clear", 32'(gnt), 32'd0);
    check("abort_busy_clear", 32'(busy), 32'd0);
    check("abort_outs_clear", {done, 2'(done_id), result, hits}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(snap));
    check("abort_idle", 32'(busy), 32'd0);

    // Held requests from reset: round-robin order and back-to-back spacing.
    rst_n = 1'b0;
    data = {8'hFF, 8'b1011_0110, 8'b1011_1011, 8'b1011_0000};
    req  = '1;
    push_exp(0, 0, 1);
    push_exp(1, 4, 2);
    push_exp(2, 2, 2);
    push_exp(3, 1, 0);
    push_exp(0, 0, 1);
    push_exp(1, 4, 2);
    push_exp(2, 2, 2);
    push_exp(0, 0, 1);
    done_cyc.delete();
    @(negedge clk);
    rst_n = 1'b1;
    wait_grant(0);
    wait_grant(1);
    wait_grant(2);
    wait_grant(3);
    wait_grant(0);
    wait_grant(1);
    wait_grant(2);
    req = 4'b0101;
    wait_grant(0);
    req = '0;
    n = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("final_idle", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(done_cyc.size()), 32'd8);
    for (int i = 1; i < done_cyc.size(); i++) begin
      check("done_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 32'd11);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/detect_scheduler.md
Name: detect_scheduler

Overview:
- Time-shares one serial pattern-detector FSM core (5 states, 3-bit state code) between NREQ requesters.
- Round-robin arbiter grants one requester at a time and latches its WORD_W-bit word.
- The word is shifted MSB-first through the core, one bit per cycle.
- Reports the final detector code, the number of terminal-state hits, and the requester ID.
- Sits between multiple bit-frame producers and a single detector resource.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WORD_W, 8, bits per job word.
- ID_W, 2, width of requester index; equals clog2(NREQ).
- HIT_W, 4, hit counter width; equals clog2(WORD_W+1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; low clears all state immediately.
- req  in  NREQ  per-requester job request, level.
- data  in  NREQ*WORD_W  flattened words; requester i uses bits [i*WORD_W +: WORD_W].
- gnt  out  NREQ  one-hot grant.
- busy  out  1  high whenever the controller is not in IDLE.
- done  out  1  one-cycle completion pulse.
- done_id  out  ID_W  index of the completed requester.
- result  out  3  final detector state code, 0..4.
- hits  out  HIT_W  count of shift steps that landed in S4.

Behaviour:
- Reset values: gnt=0, busy=0, done=0, done_id=0, result=0, hits=0, controller=IDLE, core=S0, RR pointer=0.
- Core FSM (sub-module), states S0..S4 with codes 0..4:
  - S0: 1->S1, 0->S0
  - S1: 1->S1, 0->S2
  - S2: 1->S3, 0->S0
  - S3: 1->S4, 0->S2
  - S4: 1->S1, 0->S2
- Core has synchronous clear (to S0) and enable; it holds state when enable is low.
- Controller states: IDLE, GRANT, SHIFT, DONE.
- IDLE: if any req is high at a clock edge, go to GRANT.
  - Winner is the first requester with req high, searching from pointer upward with wrap.
  - Pointer becomes winner+1 mod NREQ.
- GRANT (1 cycle):
  - gnt[winner]=1.
  - Word captured into shift register; later data changes are ignored.
  - Core cleared to S0; hit counter cleared.
- SHIFT (exactly WORD_W cycles):
  - Cycle k feeds bit WORD_W-1-k with core enabled.
  - Hit counter increments when the core's next state is S4; it cannot overflow.
- DONE (1 cycle):
  - done=1, done_id=winner.
  - result and hits registered and held until the next DONE.
  - Returns to IDLE.
- gnt is high from GRANT through DONE inclusive and deasserts in IDLE.
- Latency: req seen at edge e0 -> GRANT at cycle 1, SHIFT cycles 2..WORD_W+1, DONE at cycle WORD_W+2. One mandatory IDLE cycle separates jobs.
- req is sampled only in IDLE. Deassertion mid-job does not abort. A requester holding req after done is re-eligible, but the pointer has already passed it.
- Asynchronous reset mid-job aborts the job: no done pulse, outputs return to reset values, pointer=0.
- If no req is high, the controller remains in IDLE with busy=0.

Decomposition:
- Shared package holds:
  - core state codes S0..S4 (3-bit)
  - controller state encoding IDLE/GRANT/SHIFT/DONE (2-bit)
  - default NREQ and WORD_W.
- One sub-module, seq_fsm_core: clk, reset, clear, en, in, state[2:0], next_state[2:0].
- The arbiter pointer logic stays inline in detect_scheduler.

Test Plan:
- Reset with req=0 -> all outputs 0, busy=0 for 20 cycles. Assert reset low mid-SHIFT -> gnt=0 and busy=0 immediately, no done pulse.
- req=4'b0001, word0=8'b10110000 -> gnt=0001 at cycle 1, done at cycle 10 with done_id=0, result=0, hits=1.
- req=4'b0010, word1=8'b10111011 -> result=4, hits=2, done_id=1. word1=8'hFF -> result=1, hits=0.
- req=4'b0100, word2=8'b10110110 -> result=2, hits=2. Change data2 during SHIFT -> result unchanged.
- req=4'b1111 held from reset -> grant order 0,1,2,3,0. Each done is exactly 11 cycles after the previous one.
- After the grant to requester 2, drive req=4'b0101 -> next grant to requester 0. Drop req mid-job -> job still completes with done.
